// File: rtl/sonar_scheduler.sv
// Sonar scheduler: fires six ultrasonic rangers one at a time in
// round-robin order and times each echo pulse in microseconds.
// Ports: sys_clk, rst_n (async, low) | run, en_mask[5:0], echo[5:0]
//        -> trig[5:0], busy, result_valid, result_id[2:0],
//           result_us[15:0], result_timeout
module sonar_scheduler #(
  parameter int CLK_PER_US  = 50,
  parameter int TRIG_US     = 10,
  parameter int RISE_TO_US  = 1000,
  parameter int ECHO_MAX_US = 30000,
  parameter int GAP_US      = 10000
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [5:0]  en_mask,
  input  logic [5:0]  echo,
  output logic [5:0]  trig,
  output logic        busy,
  output logic        result_valid,
  output logic [2:0]  result_id,
  output logic [15:0] result_us,
  output logic        result_timeout
);

  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] PRE_TC = PW'(CLK_PER_US - 1);
  localparam logic [15:0] TRIG_TC = 16'(TRIG_US - 1);
  localparam logic [15:0] RISE_TC = 16'(RISE_TO_US - 1);
  localparam logic [15:0] MAX_TC  = 16'(ECHO_MAX_US - 1);
  localparam logic [15:0] MAX_US  = 16'(ECHO_MAX_US);
  localparam logic [15:0] GAP_TC  = 16'(GAP_US - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TRIG = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_MEAS = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  logic [5:0]    r_echo_s1;
  logic [5:0]    r_echo_s2;
  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic [2:0]    r_idx;
  logic [2:0]    w_idx_nxt;
  logic [2:0]    w_sel_idx;
  logic [2:0]    w_cand;
  logic          w_found;
  logic          w_load;
  logic [PW-1:0] r_pre;
  logic [15:0]   r_us;
  logic          w_tick;
  logic          w_echo;
  logic          w_go;
  logic          w_emit;
  logic [15:0]   w_emit_us;
  logic          w_emit_to;
  logic [5:0]    r_trig;
  logic          r_res_valid;
  logic [2:0]    r_res_id;
  logic [15:0]   r_res_us;
  logic          r_res_to;

  function automatic logic [2:0] wrap6(input logic [2:0] a,
                                       input logic [2:0] k);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, k};
    return (s >= 4'd6) ? 3'(s - 4'd6) : s[2:0];
  endfunction

  assign w_tick = (r_pre == PRE_TC);
  assign w_echo = r_echo_s2[r_idx];
  assign w_go   = run && (|en_mask);

  // First enabled sonar after the current one, current one last.
  always_comb begin
    w_sel_idx = r_idx;
    w_found   = 1'b0;
    w_cand    = r_idx;
    for (int k = 1; k <= 6; k++) begin
      w_cand = wrap6(r_idx, 3'(k));
      if (!w_found && en_mask[w_cand]) begin
        w_sel_idx = w_cand;
        w_found   = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_emit      = 1'b0;
    w_emit_us   = 16'd0;
    w_emit_to   = 1'b0;
    unique case (1'b1)
      (r_state == S_IDLE): begin
        if (w_go) begin
          w_state_nxt = S_TRIG;
          w_load      = 1'b1;
        end
      end
      (r_state == S_TRIG): begin
        if (w_tick && r_us == TRIG_TC)
          w_state_nxt = S_WAIT;
      end
      (r_state == S_WAIT): begin
        if (w_echo) begin
          w_state_nxt = S_MEAS;
        end else if (w_tick && r_us == RISE_TC) begin
          w_state_nxt = S_GAP;
          w_emit      = 1'b1;
          w_emit_us   = 16'hFFFF;
          w_emit_to   = 1'b1;
        end
      end
      (r_state == S_MEAS): begin
        if (!w_echo) begin
          // The fall cycle still closes the microsecond in progress,
          // so an N us pulse reports exactly N.
          w_state_nxt = S_GAP;
          w_emit      = 1'b1;
          w_emit_us   = r_us + {15'd0, w_tick};
        end else if (w_tick && r_us == MAX_TC) begin
          w_state_nxt = S_GAP;
          w_emit      = 1'b1;
          w_emit_us   = MAX_US;
          w_emit_to   = 1'b1;
        end
      end
      (r_state == S_GAP): begin
        if (w_tick && r_us == GAP_TC) begin
          w_state_nxt = w_go ? S_TRIG : S_IDLE;
          w_load      = w_go;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_idx_nxt = w_load ? w_sel_idx : r_idx;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_echo_s1 <= 6'd0;
      r_echo_s2 <= 6'd0;
    end else begin
      r_echo_s1 <= echo;
      r_echo_s2 <= r_echo_s1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= 3'd5;
      r_trig  <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_trig  <= (w_state_nxt == S_TRIG) ? (6'b1 << w_idx_nxt)
                                         : 6'd0;
    end
  end

  // Timebase restarts on every state change.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_us  <= 16'd0;
    end else if (w_state_nxt != r_state) begin
      r_pre <= '0;
      r_us  <= 16'd0;
    end else if (w_tick) begin
      r_pre <= '0;
      r_us  <= r_us + 16'd1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_id    <= 3'd0;
      r_res_us    <= 16'd0;
      r_res_to    <= 1'b0;
    end else begin
      r_res_valid <= w_emit;
      if (w_emit) begin
        r_res_id <= r_idx;
        r_res_us <= w_emit_us;
        r_res_to <= w_emit_to;
      end
    end
  end

  assign trig           = r_trig;
  assign busy           = (r_state != S_IDLE);
  assign result_valid   = r_res_valid;
  assign result_id      = r_res_id;
  assign result_us      = r_res_us;
  assign result_timeout = r_res_to;

endmodule
